// File: rtl/angle_interp.sv
// Angle interpolator: splits each encoder tooth into SUB_DIV timed slots and
// fires one indexed measurement trigger per slot. Optional macro ANGLE_INTERP_OFFSET_EN.
module angle_interp #(
  parameter int unsigned SUB_DIV      = 16,
  parameter int unsigned SUB_SHIFT    = 4,
  parameter int unsigned ACTIVE_TEETH = 40,
  parameter int unsigned MIN_PERIOD   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        motor_enable,
  input  logic        motor_block,
  input  logic        virtual_zero_flag,
  input  logic        wheel_fall,
  input  logic [31:0] speed_cnt,
`ifdef ANGLE_INTERP_OFFSET_EN
  input  logic [15:0] angle_offset,
`endif
  output logic        meas_trig,
  output logic [15:0] angle_idx,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic        slot_drop,
  output logic [15:0] drop_cnt
);

  localparam int unsigned SUB_W   = (SUB_SHIFT > 0) ? SUB_SHIFT : 1;
  localparam int unsigned TOOTH_W = (ACTIVE_TEETH > 1) ? $clog2(ACTIVE_TEETH) : 1;
  localparam int unsigned TOTAL   = ACTIVE_TEETH * SUB_DIV;
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_DIV - 1);
  localparam logic [TOOTH_W-1:0] TOOTH_LAST = TOOTH_W'(ACTIVE_TEETH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          sub_period_q, sub_period_d;
  logic [31:0]          slot_q, slot_d;
  logic [TOOTH_W-1:0]   tooth_q, tooth_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [15:0]          raw_angle_q, raw_angle_d;
  logic [15:0]          drop_q, drop_d;
  logic                 trig_q, trig_d;
  logic                 fs_q, fs_d;
  logic                 fd_q, fd_d;
  logic                 sd_q, sd_d;
  logic                 busy_q, busy_d;
  logic                 motor_ok;
  logic [16:0]          drop_sum;

  function automatic logic [31:0] clamp_period(input logic [31:0] sc);
    logic [31:0] p;
    p = sc >> SUB_SHIFT;
    return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
  endfunction

  function automatic logic [15:0] angle_of(input logic [TOOTH_W-1:0] t,
                                           input logic [SUB_W-1:0]   s);
    return (16'(t) << SUB_SHIFT) | 16'(s);
  endfunction

  assign motor_ok = motor_enable && !motor_block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sub_period_q <= '0;
      slot_q       <= '0;
      tooth_q      <= '0;
      sub_q        <= '0;
      raw_angle_q  <= '0;
      drop_q       <= '0;
      trig_q       <= 1'b0;
      fs_q         <= 1'b0;
      fd_q         <= 1'b0;
      sd_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_period_q <= sub_period_d;
      slot_q       <= slot_d;
      tooth_q      <= tooth_d;
      sub_q        <= sub_d;
      raw_angle_q  <= raw_angle_d;
      drop_q       <= drop_d;
      trig_q       <= trig_d;
      fs_q         <= fs_d;
      fd_q         <= fd_d;
      sd_q         <= sd_d;
      busy_q       <= busy_d;
    end
  end

  // Next state: motor fault aborts from anywhere; a tooth edge beats a slot expiry.
  always_comb begin
    state_d      = state_q;
    sub_period_d = sub_period_q;
    slot_d       = slot_q;
    tooth_d      = tooth_q;
    sub_d        = sub_q;
    raw_angle_d  = raw_angle_q;
    drop_d       = drop_q;
    trig_d       = 1'b0;
    fs_d         = 1'b0;
    fd_d         = 1'b0;
    sd_d         = 1'b0;
    drop_sum     = {1'b0, drop_q} + 17'(SUB_LAST - sub_q);

    if (!motor_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (virtual_zero_flag) begin
            sub_period_d = clamp_period(speed_cnt);
            tooth_d      = '0;
            sub_d        = '0;
            slot_d       = '0;
            raw_angle_d  = '0;
            drop_d       = '0;
            trig_d       = 1'b1;
            fs_d         = 1'b1;
            state_d      = RUN;
          end
        end
        RUN: begin
          if (wheel_fall) begin
            sub_period_d = clamp_period(speed_cnt);
            if (sub_q != SUB_LAST) begin
              sd_d   = 1'b1;
              drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (tooth_q == TOOTH_LAST) begin
              state_d = DONE;
            end else begin
              tooth_d     = tooth_q + TOOTH_W'(1);
              sub_d       = '0;
              slot_d      = '0;
              trig_d      = 1'b1;
              raw_angle_d = angle_of(tooth_q + TOOTH_W'(1), '0);
            end
          end else if (sub_q != SUB_LAST) begin
            if (slot_q == sub_period_q - 32'd1) begin
              sub_d       = sub_q + SUB_W'(1);
              slot_d      = '0;
              trig_d      = 1'b1;
              raw_angle_d = angle_of(tooth_q, sub_q + SUB_W'(1));
            end else begin
              slot_d = slot_q + 32'd1;
            end
          end
        end
        DONE: begin
          fd_d    = 1'b1;
          state_d = ARM;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  assign frame_done = fd_q;
  assign busy       = busy_q;
  assign slot_drop  = sd_q;
  assign drop_cnt   = drop_q;

`ifdef ANGLE_INTERP_OFFSET_EN
  logic [15:0] offset_q;
  logic [15:0] out_angle_q;
  logic        out_trig_q;
  logic        out_fs_q;
  logic [16:0] off_sum;
  logic [16:0] off_wrap;

  // Offset is applied modulo the frame length with a single compare-subtract.
  always_comb begin
    off_sum  = {1'b0, raw_angle_q} + {1'b0, offset_q};
    off_wrap = (off_sum >= 17'(TOTAL)) ? (off_sum - 17'(TOTAL)) : off_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q    <= '0;
      out_angle_q <= '0;
      out_trig_q  <= 1'b0;
      out_fs_q    <= 1'b0;
    end else begin
      if (fs_d) offset_q <= angle_offset;
      if (trig_q) out_angle_q <= off_wrap[15:0];
      out_trig_q <= trig_q;
      out_fs_q   <= fs_q;
    end
  end

  assign meas_trig   = out_trig_q;
  assign frame_start = out_fs_q;
  assign angle_idx   = out_angle_q;
`else
  assign meas_trig   = trig_q;
  assign frame_start = fs_q;
  assign angle_idx   = raw_angle_q;
`endif

endmodule

// File: tb/tb_angle_interp.sv
// Directed bench for angle_interp: table of partial frames ended by an abort,
// plus a full frame, a drop/collision sequence, async reset and restart.
module tb_angle_interp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        motor_enable = 1'b0;
  logic        motor_block = 1'b0;
  logic        virtual_zero_flag = 1'b0;
  logic        wheel_fall = 1'b0;
  logic [31:0] speed_cnt = '0;
  logic        meas_trig;
  logic [15:0] angle_idx;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        slot_drop;
  logic [15:0] drop_cnt;

  angle_interp dut (
    .clk               (clk),
    .rst               (rst),
    .motor_enable      (motor_enable),
    .motor_block       (motor_block),
    .virtual_zero_flag (virtual_zero_flag),
    .wheel_fall        (wheel_fall),
    .speed_cnt         (speed_cnt),
    .meas_trig         (meas_trig),
    .angle_idx         (angle_idx),
    .frame_start       (frame_start),
    .frame_done        (frame_done),
    .busy              (busy),
    .slot_drop         (slot_drop),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  // Output monitor, sampled on the falling edge.
  int          cyc = 0;
  int          prev_cyc = 0;
  int          exp_sp = 0;
  int unsigned mon_trig = 0, mon_fs = 0, mon_fd = 0, mon_sd = 0;
  int unsigned mon_sp_err = 0, mon_mono_err = 0;
  logic [15:0] last_angle = '0;
  logic        have_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (frame_start) mon_fs++;
      if (frame_done)  mon_fd++;
      if (slot_drop)   mon_sd++;
      if (meas_trig) begin
        mon_trig++;
        if (frame_start) have_prev = 1'b0;
        if (have_prev && angle_idx <= last_angle) mon_mono_err++;
        if (have_prev && angle_idx[3:0] != 4'd0 && (cyc - prev_cyc) != exp_sp) mon_sp_err++;
        have_prev  = 1'b1;
        prev_cyc   = cyc;
        last_angle = angle_idx;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned speed;
    int unsigned gap;
    int unsigned teeth;
    int unsigned sp;
    int unsigned trigs;
    int unsigned last;
    int unsigned drops;
    int unsigned drop_pulses;
  } vec_t;

  vec_t vt [5];

  // Frame start with a zero pulse; afterwards we sit right after the sampling edge.
  task automatic start_frame(input int unsigned speed, input string tag);
    speed_cnt = speed;
    virtual_zero_flag = 1'b1;
    tick();
    virtual_zero_flag = 1'b0;
    chk({tag, " first meas_trig"}, meas_trig, 1);
    chk({tag, " frame_start"}, frame_start, 1);
    chk({tag, " first angle_idx"}, angle_idx, 0);
    chk({tag, " busy in RUN"}, busy, 1);
  endtask

  task automatic tooth_edge(input int unsigned gap);
    repeat (gap - 1) tick();
    wheel_fall = 1'b1;
    tick();
    wheel_fall = 1'b0;
  endtask

  task automatic abort_and_rearm(input string tag);
    motor_block = 1'b1;
    tick();
    chk({tag, " busy after abort"}, busy, 0);
    tick();
    tick();
    motor_block = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int unsigned t0, fs0, fd0, sd0, sp0, mo0;
    string tag;

    vt[0] = '{speed: 1600, gap: 1600, teeth: 3,  sp: 100, trigs: 64,  last: 63,  drops: 0,  drop_pulses: 0};
    vt[1] = '{speed: 1600, gap: 1000, teeth: 2,  sp: 100, trigs: 30,  last: 41,  drops: 12, drop_pulses: 2};
    vt[2] = '{speed: 20,   gap: 120,  teeth: 2,  sp: 4,   trigs: 48,  last: 47,  drops: 0,  drop_pulses: 0};
    vt[3] = '{speed: 112,  gap: 100,  teeth: 1,  sp: 7,   trigs: 23,  last: 23,  drops: 1,  drop_pulses: 1};
    vt[4] = '{speed: 160,  gap: 160,  teeth: 12, sp: 10,  trigs: 203, last: 202, drops: 0,  drop_pulses: 0};

    #1 rst = 1'b1;
    #20;
    chk("reset meas_trig", meas_trig, 0);
    chk("reset busy", busy, 0);
    chk("reset angle_idx", angle_idx, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    motor_enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();

    // Partial frames, each terminated by motor_block a fixed time after the last edge.
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("vec%0d", i);
      t0 = mon_trig; fs0 = mon_fs; fd0 = mon_fd; sd0 = mon_sd;
      sp0 = mon_sp_err; mo0 = mon_mono_err;
      exp_sp = int'(vt[i].sp);
      start_frame(vt[i].speed, tag);
      for (int k = 0; k < int'(vt[i].teeth); k++) tooth_edge(vt[i].gap);
      repeat (vt[i].gap - 51) tick();
      abort_and_rearm(tag);
      chk({tag, " trigger count"}, mon_trig - t0, vt[i].trigs);
      chk({tag, " last angle"}, last_angle, vt[i].last);
      chk({tag, " angle_idx held"}, angle_idx, vt[i].last);
      chk({tag, " drop_cnt"}, drop_cnt, vt[i].drops);
      chk({tag, " slot_drop pulses"}, mon_sd - sd0, vt[i].drop_pulses);
      chk({tag, " spacing errors"}, mon_sp_err - sp0, 0);
      chk({tag, " ordering errors"}, mon_mono_err - mo0, 0);
      chk({tag, " frame_start pulses"}, mon_fs - fs0, 1);
      chk({tag, " no frame_done on abort"}, mon_fd - fd0, 0);
    end

    // Complete frame at constant rate.
    t0 = mon_trig; fd0 = mon_fd; sp0 = mon_sp_err; mo0 = mon_mono_err;
    exp_sp = 100;
    start_frame(1600, "full");
    for (int k = 0; k < 40; k++) tooth_edge(1600);
    chk("full frame_done at last edge", frame_done, 0);
    chk("full busy after last edge", busy, 0);
    chk("full no trigger at last edge", meas_trig, 0);
    tick();
    chk("full frame_done pulse", frame_done, 1);
    tick();
    chk("full frame_done one cycle", frame_done, 0);
    chk("full trigger count", mon_trig - t0, 640);
    chk("full last angle", last_angle, 639);
    chk("full drop_cnt", drop_cnt, 0);
    chk("full frame_done count", mon_fd - fd0, 1);
    chk("full spacing errors", mon_sp_err - sp0, 0);
    chk("full ordering errors", mon_mono_err - mo0, 0);
    repeat (4) tick();

    // Early edge coinciding with a slot expiry: one trigger at the next tooth base.
    t0 = mon_trig;
    start_frame(1600, "accel");
    tooth_edge(1000);
    chk("accel meas_trig at edge", meas_trig, 1);
    chk("accel angle_idx next tooth", angle_idx, 16);
    chk("accel slot_drop", slot_drop, 1);
    chk("accel drop_cnt", drop_cnt, 6);
    tick();
    chk("accel single trigger", meas_trig, 0);
    chk("accel slot_drop one cycle", slot_drop, 0);
    chk("accel trigger count", mon_trig - t0, 11);

    // Asynchronous reset in the middle of a frame.
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst angle_idx", angle_idx, 0);
    chk("async rst drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    t0 = mon_trig;
    repeat (300) tick();
    chk("post rst no triggers", mon_trig - t0, 0);
    chk("post rst busy", busy, 0);
    start_frame(1600, "restart");
    abort_and_rearm("restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
